// File: rtl/jtag_tap_master.sv
// jtag_tap_master: JTAG host controller issuing TAP resets, IR scans and DR scans over TCK/TMS/TDI/TDO.
// Optional macro JTAG_TRST_EN adds a TRST_N output pulsed low at the start of every TAP reset sequence.
module jtag_tap_master #(
    parameter int IR_WIDTH = 4,
    parameter int DR_MAX   = 32,
    parameter int CLK_DIV  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [1:0]                  cmd_op,
    input  logic [$clog2(DR_MAX+1)-1:0] cmd_len,
    input  logic [DR_MAX-1:0]           cmd_data,
    output logic                        rsp_valid,
    output logic [DR_MAX-1:0]           rsp_data,
    output logic                        tck,
    output logic                        tms,
    output logic                        tdi,
`ifdef JTAG_TRST_EN
    output logic                        trst_n,
`endif
    input  logic                        tdo
);
    localparam int LW = $clog2(DR_MAX + 1);
    localparam int SW = $clog2(DR_MAX + 8);
    localparam int DW = $clog2(CLK_DIV + 1);

    typedef enum logic [2:0] {INIT_RST, IDLE, PRE, SHIFT, POST, DONE} state_t;

    state_t            state, state_next;
    logic [DW-1:0]     div;
    logic [SW-1:0]     step, n_q, n_cmd;
    logic [1:0]        op_q;
    logic              auto_q;
    logic [DR_MAX-1:0] data_q, cap;
    logic              running, rise, fall, last, accept;

    // Event decode: TCK edges, end of the current TMS segment, command acceptance, clamped scan length
    always_comb begin
        running = state inside {INIT_RST, PRE, SHIFT, POST};
        rise    = running && !tck && div == DW'(CLK_DIV - 1);
        fall    = running && tck && div == DW'(CLK_DIV - 1);
        last    = (state == INIT_RST) ? step == SW'(5) :
                  (state == PRE)      ? step == (op_q == 2'b01 ? SW'(3) : SW'(2)) :
                  (state == SHIFT)    ? step == n_q - SW'(1) : step == SW'(1);
        accept  = cmd_valid && cmd_ready;
        n_cmd   = (cmd_op == 2'b01)           ? SW'(IR_WIDTH) :
                  (cmd_len == '0)             ? SW'(1) :
                  (cmd_len > LW'(DR_MAX))     ? SW'(DR_MAX) : SW'(cmd_len);
    end

    // State register; step counts TCKs within the current state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT_RST;
            step  <= '0;
        end else begin
            state <= state_next;
            step  <= (state_next != state) ? '0 : fall ? step + SW'(1) : step;
        end
    end

    // Next state: segments advance on the TCK falling edge that ends their last bit
    always_comb begin
        state_next = state;
        case (state)
            INIT_RST: if (fall && last) state_next = auto_q ? IDLE : DONE;
            IDLE, DONE: state_next = cmd_valid ? (cmd_op[1] ? INIT_RST : PRE) : IDLE;
            PRE:      if (fall && last) state_next = SHIFT;
            SHIFT:    if (fall && last) state_next = POST;
            POST:     if (fall && last) state_next = DONE;
            default:  state_next = INIT_RST;
        endcase
    end

    // Datapath: TCK divider, command latch, TDI/TDO shift registers and response update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div      <= '0;
            tck      <= 1'b0;
            op_q     <= 2'b10;
            auto_q   <= 1'b1;
            n_q      <= '0;
            data_q   <= '0;
            cap      <= '0;
            rsp_data <= '0;
        end else begin
            if (running) begin
                div <= (div == DW'(CLK_DIV - 1)) ? '0 : div + DW'(1);
                tck <= (div == DW'(CLK_DIV - 1)) ? ~tck : tck;
            end
            if (accept) begin
                op_q   <= cmd_op;
                auto_q <= 1'b0;
                n_q    <= n_cmd;
                data_q <= cmd_data;
                cap    <= '0;
            end
            if (rise && state == SHIFT) cap <= {tdo, cap[DR_MAX-1:1]};
            if (fall && state == SHIFT) data_q <= data_q >> 1;
            if (fall && last && state == POST) rsp_data <= cap >> (SW'(DR_MAX) - n_q);
        end
    end

    // Outputs: TMS pattern per segment, TDI from the data shifter, handshake flags
    always_comb begin
        cmd_ready = state == IDLE || state == DONE;
        rsp_valid = state == DONE;
        tms = (state == INIT_RST) ? step < SW'(5) :
              (state == PRE)      ? (op_q == 2'b01 ? step < SW'(2) : step == '0) :
              (state == SHIFT)    ? last :
              (state == POST)     ? step == '0 : 1'b0;
        tdi = state == SHIFT && data_q[0];
`ifdef JTAG_TRST_EN
        trst_n = !(state == INIT_RST && step < SW'(2));
`endif
    end
endmodule

// File: tb/tb_jtag_tap_master.sv
// tb_jtag_tap_master: randomized bench for jtag_tap_master against a JTAG target model and a scan-level reference.
module tb_jtag_tap_master;
    localparam int CLK_DIV = 4;
    localparam logic [31:0] IDCODE = 32'h1234_5677;
    localparam int TLR = 0, RTI = 1, SDS = 2, CDR = 3, SHDR = 4, E1DR = 5, PDR = 6, E2DR = 7, UDR = 8;
    localparam int SIS = 9, CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;

    logic        clk = 0, rst_n = 1, cmd_valid = 0;
    logic [1:0]  cmd_op = 0;
    logic [5:0]  cmd_len = 0;
    logic [31:0] cmd_data = 0;
    logic        cmd_ready, rsp_valid, tck, tms, tdi, tdo = 0;
    logic [31:0] rsp_data;
`ifdef JTAG_TRST_EN
    logic        trst_n;
`endif

    jtag_tap_master #(.IR_WIDTH(4), .DR_MAX(32), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .tck(tck), .tms(tms), .tdi(tdi),
`ifdef JTAG_TRST_EN
        .trst_n(trst_n),
`endif
        .tdo(tdo));

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] m64(input int n);
        return (n >= 64) ? '1 : (64'd1 << n) - 64'd1;
    endfunction

    // JTAG target: standard 16-state TAP with IR capture 0001, IDCODE and BYPASS
    int          tap_st = TLR;
    logic [3:0]  tap_ir = 4'h7, ir_sr = 0;
    logic [31:0] dr_sr = 0;
    logic        bp = 0;

    function automatic int nxt(input int s, input logic m);
        case (s)
            TLR: return m ? TLR : RTI;    RTI: return m ? SDS : RTI;
            SDS: return m ? SIS : CDR;    CDR: return m ? E1DR : SHDR;
            SHDR: return m ? E1DR : SHDR; E1DR: return m ? UDR : PDR;
            PDR: return m ? E2DR : PDR;   E2DR: return m ? UDR : SHDR;
            UDR: return m ? SDS : RTI;    SIS: return m ? TLR : CIR;
            CIR: return m ? E1IR : SHIR;  SHIR: return m ? E1IR : SHIR;
            E1IR: return m ? UIR : PIR;   PIR: return m ? E2IR : PIR;
            E2IR: return m ? UIR : SHIR;  default: return m ? SDS : RTI;
        endcase
    endfunction

    always @(posedge tck) begin
        case (tap_st)
            CDR: begin dr_sr <= IDCODE; bp <= 1'b0; end
            SHDR: begin dr_sr <= {tdi, dr_sr[31:1]}; bp <= tdi; end
            CIR: ir_sr <= 4'b0001;
            SHIR: ir_sr <= {tdi, ir_sr[3:1]};
            UIR: tap_ir <= ir_sr;
            TLR: tap_ir <= 4'h7;
            default: ;
        endcase
        tap_st <= nxt(tap_st, tms);
    end

    always @(negedge tck)
        tdo <= (tap_st == SHDR) ? (tap_ir == 4'h7 ? dr_sr[0] : bp) : (tap_st == SHIR) ? ir_sr[0] : 1'b0;

    // Scan-level reference: one entry per expected sequence
    typedef struct {
        logic        kind;
        logic [1:0]  op;
        int          n;
        logic [31:0] data;
        logic [31:0] rsp;
    } exp_t;
    exp_t        expq[$];
    logic [3:0]  cur_ir = 4'h7;
    logic [31:0] last_rsp = 0;

    function automatic void exp_seq(input logic [1:0] op, input int n, output logic [63:0] v, output int len);
        int hl;
        v = 0;
        if (op[1]) begin
            v = 64'b011111;
            len = 6;
        end else begin
            hl = (op == 2'b01) ? 4 : 3;
            v = (op == 2'b01) ? 64'b0011 : 64'b001;
            v[hl + n - 1] = 1'b1;
            v[hl + n] = 1'b1;
            len = hl + n + 2;
        end
    endfunction

    function automatic void expect_cmd(input logic [1:0] op, input int len, input logic [31:0] data);
        exp_t e;
        e.kind = 1;
        e.op = op;
        e.data = data;
        e.n = op[1] ? 6 : (op == 2'b01) ? 4 : (len == 0) ? 1 : (len > 32) ? 32 : len;
        if (op[1]) begin
            e.rsp = last_rsp;
            cur_ir = 4'h7;
        end else if (op == 2'b01) begin
            e.rsp = 32'h1;
            cur_ir = data[3:0];
        end else begin
            e.rsp = 32'((cur_ir == 4'h7 ? {32'h0, IDCODE} : {31'h0, data, 1'b0}) & m64(e.n));
        end
        last_rsp = e.rsp;
        expq.push_back(e);
    endfunction

    function automatic void expect_init();
        exp_t e;
        e.kind = 0; e.op = 2'b10; e.n = 6; e.data = 0; e.rsp = 0;
        expq.push_back(e);
    endfunction

    // Compare process: pin timing, TMS/TDI traces and responses against the reference
    logic [63:0] tms_vec = 0, tdi_vec = 0, last_tms = 0, last_tdi = 0;
    int          ntck = 0, since_rise = 0, high_cnt = 0, trst_low = 0, last_ntck = 0, rsp_pulses = 0;
    logic        tck_p = 0, tms_p = 1, tdi_p = 0, rdy_p = 0, rv_p = 0;
    logic [31:0] held = 0;

    always @(negedge clk) begin : mon
        exp_t        e;
        logic [63:0] ev;
        int          el, hl;
        if (!rst_n) begin
            ntck = 0; tms_vec = 0; tdi_vec = 0; since_rise = 0; high_cnt = 0; trst_low = 0;
            held = 0; rdy_p = 0; rv_p = 0;
        end else begin
            if (tms !== tms_p || tdi !== tdi_p) check("pin_change_tck_low", tck, 0);
            since_rise++;
            if (tck) high_cnt++;
            if (tck && !tck_p) begin
                if (ntck > 0) check("tck_period", since_rise, 2 * CLK_DIV);
                since_rise = 0;
                if (ntck < 64) begin
                    tms_vec[ntck] = tms;
                    tdi_vec[ntck] = tdi;
                end
                ntck++;
            end
            if (!tck && tck_p) begin
                check("tck_high", high_cnt, CLK_DIV);
                high_cnt = 0;
            end
`ifdef JTAG_TRST_EN
            if (!trst_n) trst_low++;
`endif
            if (rsp_valid) begin
                check("rsp_pulse", rv_p, 0);
                rsp_pulses++;
            end else begin
                check("rsp_hold", rsp_data, held);
            end
            if (rsp_valid || (cmd_ready && !rdy_p)) begin
                if (expq.size() == 0) begin
                    check("unexpected_end", 1, 0);
                end else begin
                    e = expq.pop_front();
                    check("end_kind", rsp_valid, e.kind);
                    exp_seq(e.op, e.n, ev, el);
                    check("tck_count", ntck, el);
                    check("tms_seq", tms_vec, ev);
                    check("tap_rti", tap_st, RTI);
                    if (e.kind && !e.op[1]) begin
                        hl = (e.op == 2'b01) ? 4 : 3;
                        check("tdi_shift", (tdi_vec >> hl) & m64(e.n), {32'h0, e.data} & m64(e.n));
                        check("rsp_data", rsp_data, e.rsp);
                        held = e.rsp;
                    end
                    if (e.kind && e.op[1]) check("rsp_keep_on_reset", rsp_data, held);
                    if (e.kind && e.op == 2'b01) check("tap_ir", tap_ir, e.data[3:0]);
`ifdef JTAG_TRST_EN
                    if (e.kind && e.op[1]) check("trst_low", trst_low, 4 * CLK_DIV);
`endif
                end
                last_ntck = ntck; last_tms = tms_vec; last_tdi = tdi_vec;
                ntck = 0; tms_vec = 0; tdi_vec = 0; trst_low = 0;
            end
            rdy_p = cmd_ready;
            rv_p = rsp_valid;
        end
        tck_p = tck; tms_p = tms; tdi_p = tdi;
    end

    task automatic issue(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
        int t = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_op = op; cmd_len = len; cmd_data = data;
        while (!cmd_ready && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 4000) begin
            check("issue_timeout", t, 0);
            cmd_valid = 0;
            return;
        end
        expect_cmd(op, int'(len), data);
        @(posedge clk);
        #1;
        cmd_valid = 0;
        cmd_op = 2'($urandom);
        cmd_len = 6'($urandom);
        cmd_data = $urandom;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((expq.size() != 0 || !cmd_ready) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        tests++;
        if (t >= 5000) begin
            fails++;
            $display("FAIL wait_done: timeout after %0d cycles, %0d pending", t, expq.size());
        end
    endtask

    initial begin
        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        check("reset_tck", tck, 0);
        check("reset_tms", tms, 1);
        check("reset_tdi", tdi, 0);
        check("reset_ready", cmd_ready, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_data", rsp_data, 0);
`ifdef JTAG_TRST_EN
        check("reset_trst", trst_n, 0);
`endif
        expect_init();
        #2 rst_n = 1;
        wait_done();
        check("init_ntck", last_ntck, 6);
        check("init_tms", last_tms, 64'b011111);
        check("init_no_rsp", rsp_pulses, 0);

        issue(2'b01, 0, 32'h7);
        wait_done();
        check("ir7_ntck", last_ntck, 10);
        check("ir7_tms", last_tms, 64'h183);
        check("ir7_tdi", (last_tdi >> 4) & 64'hF, 64'h7);
        check("ir7_rsp", rsp_data, 32'h1);
        check("ir7_tap_ir", tap_ir, 4'h7);

        issue(2'b01, 0, 32'hF);
        issue(2'b00, 8, 32'hA5);
        wait_done();
        check("bypass_ntck", last_ntck, 13);
        check("bypass_rsp", rsp_data, 32'h4A);

        issue(2'b01, 0, 32'h7);
        wait_done();
        el_pulses_reset();
        issue(2'b00, 32, 32'h0);
        wait_done();
        check("idcode_rsp", rsp_data, 32'h1234_5677);
        check("idcode_pulses", rsp_pulses, 1);

        issue(2'b00, 0, 32'h1);
        wait_done();
        check("len0_ntck", last_ntck, 6);
        issue(2'b00, 40, $urandom);
        wait_done();
        check("len40_ntck", last_ntck, 37);
        issue(2'b10, 5, $urandom);
        wait_done();
        check("tapreset_ntck", last_ntck, 6);

        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom_range(0, 3)), 6'($urandom_range(0, 40)), $urandom);
            if ($urandom_range(0, 3) == 0) wait_done();
        end
        wait_done();

        issue(2'b00, 32, $urandom);
        repeat (100) @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("abort_tck", tck, 0);
        check("abort_tms", tms, 1);
        check("abort_ready", cmd_ready, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        expq.delete();
        cur_ir = 4'h7;
        last_rsp = 0;
        el_pulses_reset();
        repeat (3) @(negedge clk);
        check("abort_rsp_data", rsp_data, 0);
        expect_init();
        #2 rst_n = 1;
        wait_done();
        check("reinit_ntck", last_ntck, 6);
        check("reinit_no_rsp", rsp_pulses, 0);
        issue(2'b01, 0, 32'h8);
        wait_done();
        check("post_abort_ir_rsp", rsp_data, 32'h1);
        check("post_abort_tap_ir", tap_ir, 4'h8);
        issue(2'b00, 12, $urandom);
        wait_done();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    task automatic el_pulses_reset();
        rsp_pulses = 0;
    endtask
endmodule

// File: doc/jtag_tap_master.md
Name: jtag_tap_master

Overview:
JTAG host-side controller that drives TCK/TMS/TDI into a target TAP and samples TDO. It issues IR scans that load instruction codes (BYPASS 4'hF, SAMPLE 4'h1, IDCODE 4'h7, USERCODE 4'h8, etc.) and DR scans of up to DR_MAX bits. It also issues TAP resets. It sits between a system-side command interface and the JTAG pins, and is used as the bench/board-side initiator for our TAP logic.

Parameters:
IR_WIDTH, 4, instruction register length; IR scans always shift exactly this many bits.
DR_MAX, 32, maximum DR scan length and width of CMD_DATA/RSP_DATA.
CLK_DIV, 4, CLK cycles per TCK half-period (>=1); TCK period = 2*CLK_DIV CLK.

Ports:
CLK  input  1  system clock.
RST_N  input  1  asynchronous active-low reset.
CMD_VALID  input  1  command request.
CMD_READY  output  1  controller idle in Run-Test/Idle, command accepted when VALID&&READY.
CMD_OP  input  2  00 DR scan, 01 IR scan, 10 TAP reset, 11 reserved (treated as TAP reset).
CMD_LEN  input  $clog2(DR_MAX+1)  DR scan length in bits; ignored for IR/reset.
CMD_DATA  input  DR_MAX  TDI data, LSB shifted first.
RSP_VALID  output  1  one-CLK pulse on scan/reset completion.
RSP_DATA  output  DR_MAX  captured TDO bits, LSB = first bit out, right-aligned, unused upper bits 0.
TCK  output  1  JTAG clock, idles low.
TMS  output  1  JTAG mode select.
TDI  output  1  JTAG data to target.
TDO  input  1  JTAG data from target.

Behaviour:
- Reset (async, RST_N low): TCK=0, TMS=1, TDI=0, CMD_READY=0, RSP_VALID=0, RSP_DATA=0. A reset mid-scan aborts immediately; no response is issued.
- After RST_N rises, the controller runs an automatic TAP reset sequence with no RSP_VALID, then asserts CMD_READY.
- TCK generation: a divider counter produces TCK. TMS/TDI change only in the CLK where TCK falls (or while TCK is low before the first rise). TDO is registered in the CLK where TCK rises. Every TCK cycle is exactly 2*CLK_DIV CLK, with low phase first.
- Per-TCK TMS sequences, starting from Run-Test/Idle:
  - TAP reset: TMS 1,1,1,1,1,0. 6 TCK; ends in RTI.
  - IR scan: 1,1,0,0 (Sel-DR, Sel-IR, Capture-IR, Shift-IR), then IR_WIDTH shift TCKs with TMS=0, except TMS=1 on the last bit (Exit1-IR). Then 1 (Update-IR), 0 (RTI). Total IR_WIDTH+6 TCK.
  - DR scan: 1,0,0, then N shift TCKs (last with TMS=1), then 1, 0. Total N+5 TCK.
- DR length rules: N = CMD_LEN; N=0 is treated as 1; N>DR_MAX is clamped to DR_MAX.
- Shift data: the TDI bit for shift k is CMD_DATA[k]. The TDO bit sampled on shift k's rising edge goes to RSP_DATA[k].
- States: INIT_RST, IDLE, PRE (header TMS bits), SHIFT, POST (update/RTI bits), DONE. DONE lasts one CLK: RSP_VALID=1 and CMD_READY=1 in the same cycle.
- Handshake: CMD_READY=1 only in IDLE/DONE. CMD_OP/LEN/DATA are latched on acceptance, so inputs may change afterwards. A command accepted in the DONE cycle starts without an idle TCK.
- RSP_DATA is updated only at DONE and holds until the next DONE. For a TAP reset command RSP_DATA is unchanged.
- In IDLE: TCK held low, TMS=0, TDI=0 (target stays in RTI).

Optional Feature:
JTAG_TRST_EN:
- Defined: adds output TRST_N (1 bit), reset value 0. During INIT_RST and every TAP-reset command, TRST_N is held low for the first 2 TCK periods of the sequence and high otherwise. The TMS sequence is still issued.
- Undefined: no TRST_N port; reset is by TMS only.

Test Plan:
- Release RST_N with no command -> 6 TCK with TMS 1,1,1,1,1,0, then CMD_READY=1; no RSP_VALID; TCK period exactly 8 CLK (CLK_DIV=4).
- IR scan with CMD_DATA=4'h7 against a TAP model -> TMS 1,1,0,0,0,0,0,1,1,0; TDI during shift 1,1,1,0; model IDCODE_SELECT active after Update-IR; RSP_DATA=model IR capture 4'b0001.
- IR 4'hF (BYPASS), then DR scan LEN=8 DATA=8'hA5 -> 13 TCK; RSP_DATA=8'h4A (bypass delay of one bit, capture bit 0).
- IR 4'h7, then DR scan LEN=32 DATA=0 against a model with IDCODE 32'h1234_5677 -> RSP_DATA=32'h1234_5677; RSP_VALID pulses exactly once.
- DR scan with LEN=0 -> one shift TCK, 6 TCK total. LEN=40 -> clamped to 32, 37 TCK.
- RST_N pulsed low mid-DR shift -> TCK=0/TMS=1 immediately, no RSP_VALID. Init sequence reruns; the next IR scan completes correctly. With JTAG_TRST_EN: TRST_N is low for 16 CLK at the start of each reset sequence.
